// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers (start/busy/done handshake, flush abort).
// Define ALU_MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU are accepted as no-ops.
module alu_muldiv #(
    parameter int NB_REG = 32,
    parameter int NB_OP  = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [NB_OP-1:0]  i_op,
    input  logic [NB_REG-1:0] i_a,
    input  logic [NB_REG-1:0] i_b,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_zero,
    output logic [NB_REG-1:0] o_hi,
    output logic [NB_REG-1:0] o_lo
);

    localparam int CNT_W = (NB_REG > 1) ? $clog2(NB_REG) : 1;

    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(0);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(1);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(2);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(3);
    localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(4);
    localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(5);

`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*NB_REG-1:0] acc;
    logic [NB_REG-1:0]   opnd;
    logic                op_div;
    logic                neg_lo;
    logic                neg_hi;
    logic                div_zero;
    logic [NB_REG-1:0]   hi_q, lo_q;

    // Operand decode at acceptance
    logic              accept, is_mul, is_div, is_signed, goes_run;
    logic              a_neg, b_neg;
    logic [NB_REG-1:0] a_mag, b_mag;

    assign accept    = (state == ST_IDLE) && i_start && !i_flush;
    assign is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign is_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    assign is_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign goes_run  = is_mul || (DIV_EN && is_div);
    assign a_neg     = is_signed && i_a[NB_REG-1];
    assign b_neg     = is_signed && i_b[NB_REG-1];
    assign a_mag     = a_neg ? -i_a : i_a;
    assign b_mag     = b_neg ? -i_b : i_b;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [NB_REG:0]     mul_sum;
    logic [2*NB_REG-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*NB_REG-1:NB_REG]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_next = {mul_sum, acc[NB_REG-1:1]};

    // Divide step: acc = {partial remainder, dividend bits becoming quotient bits}
    logic [2*NB_REG-1:0] div_next;

`ifdef ALU_MULDIV_DIV_EN
    logic [NB_REG:0] div_shift, div_diff;
    logic            div_ge;

    assign div_shift = acc[2*NB_REG-1:NB_REG-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    // A zero divisor holds the dividend so it can be returned in HI at the end.
    assign div_next  = div_zero ? acc
                     : {(div_ge ? div_diff[NB_REG-1:0] : div_shift[NB_REG-1:0]),
                        acc[NB_REG-2:0], div_ge};
`else
    assign div_next  = acc;
`endif

    logic [2*NB_REG-1:0] step_next;
    logic                last_iter;

    assign step_next = op_div ? div_next : mul_next;
    assign last_iter = (cnt == CNT_W'(NB_REG - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = goes_run ? ST_RUN : ST_DONE;
            ST_RUN: begin
                if (i_flush)        state_next = ST_IDLE;
                else if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (accept) begin
            cnt      <= '0;
            acc      <= {{NB_REG{1'b0}}, (is_mul ? b_mag : a_mag)};
            opnd     <= is_mul ? a_mag : b_mag;
            op_div   <= is_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= is_mul ? (a_neg ^ b_neg) : a_neg;
            div_zero <= DIV_EN && is_div && (i_b == '0);
            if (i_op == OP_MTHI) hi_q <= i_a;
            if (i_op == OP_MTLO) lo_q <= i_a;
        end else if (state == ST_RUN && !i_flush) begin
            acc <= step_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                if (!op_div) begin
                    {hi_q, lo_q} <= neg_lo ? -step_next : step_next;
                end else if (div_zero) begin
                    lo_q <= '1;
                    hi_q <= neg_hi ? -step_next[NB_REG-1:0] : step_next[NB_REG-1:0];
                end else begin
                    lo_q <= neg_lo ? -step_next[NB_REG-1:0] : step_next[NB_REG-1:0];
                    hi_q <= neg_hi ? -step_next[2*NB_REG-1:NB_REG]
                                   : step_next[2*NB_REG-1:NB_REG];
                end
            end
        end
    end

    // A flush in the DONE cycle suppresses the completion pulse; the write already happened.
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE) && !i_flush;
    assign o_div_zero = o_done && div_zero;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, the multi-cycle companion to the single-cycle ALU in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over a start/busy/done handshake, and holds HI/LO for MFHI/MFLO. The width is parametrised, and a flush input aborts an operation in flight when the pipeline squashes the issuing instruction.

## Interface
- `NB_REG`, 32: operand and HI/LO width; must be ≥ 4.
- `NB_OP`, 3: operation code width.
- `i_clock` in 1: clock, all state updates on rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_start` in 1: request; accepted only in IDLE.
- `i_op` in NB_OP: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- `i_a` in NB_REG: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `i_b` in NB_REG: rt operand (multiplier or divisor).
- `i_flush` in 1: abort current operation.
- `o_busy` out 1: high in RUN and DONE.
- `o_done` out 1: one-cycle completion pulse.
- `o_div_zero` out 1: high with `o_done` when a DIV/DIVU had divisor 0.
- `o_hi` out NB_REG: HI register (MFHI source).
- `o_lo` out NB_REG: LO register (MFLO source).

## Operation
- **States:**
  - IDLE → RUN on accepted MULT/MULTU/DIV/DIVU.
  - IDLE → DONE on accepted MTHI/MTLO/no-op.
  - RUN → DONE when the iteration counter reaches NB_REG-1.
  - DONE → IDLE unconditionally.
- **Capture:** on acceptance, latch operands. Signed ops store magnitudes plus the result sign: product sign = a^b, quotient sign = a^b, remainder sign = a.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, 2·NB_REG-bit accumulator.
  - On entry to DONE: {HI,LO} = product, negated if the sign flag is set.
- **Divide:** restoring, one quotient bit per RUN cycle.
  - On entry to DONE: LO = quotient, HI = remainder, each sign-corrected.
  - Signed most-negative ÷ -1 gives LO = most-negative, HI = 0 (falls out of the magnitude path).
- **Divide by zero:** detected at acceptance.
  - Runs the full NB_REG cycles.
  - Writes LO = all ones, HI = i_a as captured.
  - Asserts `o_div_zero` with `o_done`.
- **MTHI/MTLO:** HI or LO is written with i_a on the accepting edge; the other register is unchanged.
- **Flush:**
  - In RUN or DONE: next state IDLE, HI/LO unchanged, no `o_done`.
  - In DONE: the write was already committed on DONE entry and is not reverted.
  - In IDLE: blocks acceptance of a coincident `i_start`.
- `i_start` outside IDLE is ignored; no queueing.

## Timing
- **Reset:** state IDLE, counter 0, HI = LO = 0, `o_busy` = `o_done` = `o_div_zero` = 0.
- **MULT/DIV latency:**
  - `i_start` sampled at edge k; RUN spans edges k+1 through k+NB_REG.
  - HI/LO are updated and `o_done` is high in the cycle after edge k+NB_REG.
  - Back-to-back issue is possible at edge k+NB_REG+2.
- **MTHI/MTLO:** register written at edge k; `o_done` high for the cycle after edge k.
- `o_busy` is registered; it is high from the cycle after acceptance through the `o_done` cycle inclusive.
- `o_hi`/`o_lo` are direct register outputs, stable except on DONE entry or an MTHI/MTLO edge.
- Reset asserted mid-RUN returns to the reset values immediately, with no `o_done`.

## Configuration
- `ALU_MULDIV_DIV_EN` defined:
  - The divider datapath is built.
  - DIV/DIVU behave as above.
- Undefined:
  - No divider logic is built.
  - DIV/DIVU are accepted, go IDLE → DONE, and leave HI/LO unchanged.
  - `o_div_zero` is tied 0.

## Test plan
- MULT, NB_REG = 32: i_a = 0xFFFFFFFF (-1), i_b = 0x00000005 → after 33 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFB, one `o_done` pulse.
- MULTU: i_a = 0xFFFFFFFF, i_b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV: i_a = -7 (0xFFFFFFF9), i_b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU: i_a = 100, i_b = 0 → LO = 0xFFFFFFFF, HI = 100, `o_div_zero` = 1 with `o_done`.
- MTLO 0x1234 then MTHI 0xABCD → LO updated on the first edge, `o_done` 1 cycle later, HI = 0xABCD after the second. Then issue MULT and assert `i_flush` at RUN cycle 10 → IDLE, no `o_done`, HI/LO still 0xABCD/0x1234.
- Reset (i_reset = 0) mid-RUN → `o_busy` = 0, HI = LO = 0 immediately. `i_start` while `o_busy` → ignored, result matches the first operation only.
